// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared constants, FSM state types and divisor helper for uart.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Clock cycles per oversample tick, never below one.
    function automatic int calc_divisor(input int clk_hz, input int bit_rate);
        int d;
        d = clk_hz / (bit_rate * OVERSAMPLE);
        return (d < 1) ? 1 : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_gen
// Brief    : Free-running divider producing a one-clock 16x baud tick.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
    parameter int DIVISOR = 1
) (
    input  logic clk,
    input  logic reset,
    output logic o_enable16
);

    localparam int c_cnt_w = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DIVISOR - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_enable16 = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/uart.sv
`default_nettype none
// ============================================================================
// Module   : uart
// Brief    : 8N1 UART transmitter and receiver sharing one 16x baud tick.
//            Define UART_FRAMING_CHECK_EN to enable framing-error reporting.
// Revision : 1.0 - initial release
// ============================================================================
module uart
    import uart_pkg::*;
#(
    parameter int freq_hz = 100000000,
    parameter int baud    = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic       uart_txd,
    output logic [7:0] rx_data,
    output logic       rx_avail,
    output logic       rx_error,
    input  logic       rx_ack,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    output logic       tx_busy
);

    localparam int c_divisor = calc_divisor(freq_hz, baud);
    localparam int c_tick_w  = $clog2(OVERSAMPLE);
    localparam int c_bit_w   = $clog2(DATA_BITS);

    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(OVERSAMPLE - 1);
    localparam logic [c_tick_w-1:0] c_tick_mid  = c_tick_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(DATA_BITS - 1);

    logic w_tick;

    uart_baud_gen #(
        .DIVISOR (c_divisor)
    ) u_baud_gen (
        .clk        (clk),
        .reset      (reset),
        .o_enable16 (w_tick)
    );

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t              r_tx_state;
    logic [c_tick_w-1:0]    r_tx_tick;
    logic [c_bit_w-1:0]     r_tx_bit;
    logic [DATA_BITS-1:0]   r_tx_shift;
    logic                   r_txd;
    logic                   r_tx_busy;
    logic                   w_tx_bit_end;

    assign w_tx_bit_end = w_tick && (r_tx_tick == c_tick_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_tick  <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
            r_tx_busy  <= 1'b0;
        end else begin
            if (w_tick && (r_tx_state != TX_IDLE)) begin
                r_tx_tick <= r_tx_tick + 1'b1;
            end
            case (r_tx_state)
                TX_IDLE: begin
                    if (tx_wr) begin
                        r_tx_shift <= tx_data;
                        r_tx_tick  <= '0;
                        r_txd      <= 1'b0;
                        r_tx_busy  <= 1'b1;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_tx_bit_end) begin
                        r_txd      <= r_tx_shift[0];
                        r_tx_bit   <= '0;
                        r_tx_state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (w_tx_bit_end) begin
                        if (r_tx_bit == c_bit_last) begin
                            r_txd      <= 1'b1;
                            r_tx_state <= TX_STOP;
                        end else begin
                            r_tx_shift <= r_tx_shift >> 1;
                            r_txd      <= r_tx_shift[1];
                            r_tx_bit   <= r_tx_bit + 1'b1;
                        end
                    end
                end
                TX_STOP: begin
                    if (w_tx_bit_end) begin
                        r_tx_busy  <= 1'b0;
                        r_tx_state <= TX_IDLE;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    assign uart_txd = r_txd;
    assign tx_busy  = r_tx_busy;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [1:0]             r_sync;
    logic                   w_rxd;
    rx_state_t              r_rx_state;
    logic [c_tick_w-1:0]    r_rx_tick;
    logic [c_bit_w-1:0]     r_rx_bit;
    logic [DATA_BITS-1:0]   r_rx_shift;
    logic [DATA_BITS-1:0]   r_rx_data;
    logic                   r_rx_avail;
    logic                   r_rx_hold;
    logic                   w_rx_mid;
    logic                   w_rx_bit_end;
`ifdef UART_FRAMING_CHECK_EN
    logic                   r_rx_error;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], uart_rxd};
        end
    end

    assign w_rxd        = r_sync[1];
    assign w_rx_mid     = w_tick && (r_rx_tick == c_tick_mid);
    assign w_rx_bit_end = w_tick && (r_rx_tick == c_tick_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_state <= RX_IDLE;
            r_rx_tick  <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_avail <= 1'b0;
            r_rx_hold  <= 1'b0;
`ifdef UART_FRAMING_CHECK_EN
            r_rx_error <= 1'b0;
`endif
        end else begin
            // Acknowledge first so a byte completing this cycle overrides it.
            if (rx_ack) begin
                r_rx_avail <= 1'b0;
`ifdef UART_FRAMING_CHECK_EN
                r_rx_error <= 1'b0;
`endif
            end
            if (w_tick && (r_rx_state != RX_IDLE)) begin
                r_rx_tick <= r_rx_tick + 1'b1;
            end
            case (r_rx_state)
                RX_IDLE: begin
                    if (!w_rxd) begin
                        r_rx_tick  <= '0;
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (w_rx_mid) begin
                        if (w_rxd) begin
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_rx_tick  <= '0;
                            r_rx_bit   <= '0;
                            r_rx_state <= RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    if (w_rx_bit_end) begin
                        r_rx_shift <= {w_rxd, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_bit == c_bit_last) begin
                            r_rx_state <= RX_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 1'b1;
                        end
                    end
                end
                RX_STOP: begin
                    // A low stop bit leaves the line low; wait for it to rise so
                    // the same low level is not taken as a new start bit.
                    if (r_rx_hold) begin
                        if (w_rxd) begin
                            r_rx_hold  <= 1'b0;
                            r_rx_state <= RX_IDLE;
                        end
                    end else if (w_rx_bit_end) begin
`ifdef UART_FRAMING_CHECK_EN
                        if (w_rxd) begin
                            r_rx_data  <= r_rx_shift;
                            r_rx_avail <= 1'b1;
                            r_rx_error <= 1'b0;
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_rx_error <= 1'b1;
                            r_rx_hold  <= 1'b1;
                        end
`else
                        r_rx_data  <= r_rx_shift;
                        r_rx_avail <= 1'b1;
                        if (w_rxd) begin
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_rx_hold <= 1'b1;
                        end
`endif
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    assign rx_data  = r_rx_data;
    assign rx_avail = r_rx_avail;
`ifdef UART_FRAMING_CHECK_EN
    assign rx_error = r_rx_error;
`else
    assign rx_error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart
// Brief    : Self-checking bench for uart at 100 MHz / 1152000 baud (80 clk/bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart;

    localparam int c_freq = 100000000;
    localparam int c_baud = 1152000;
    localparam int c_bit  = 80;
    localparam int c_frame = 10 * c_bit;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       rxd_drv  = 1'b1;
    logic       loop_en  = 1'b0;
    logic       rx_ack   = 1'b0;
    logic       tx_wr    = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       uart_rxd;
    logic       uart_txd;
    logic [7:0] rx_data;
    logic       rx_avail;
    logic       rx_error;
    logic       tx_busy;

    assign uart_rxd = loop_en ? uart_txd : rxd_drv;

    always #5 clk = ~clk;

    uart #(
        .freq_hz (c_freq),
        .baud    (c_baud)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd),
        .rx_data  (rx_data),
        .rx_avail (rx_avail),
        .rx_error (rx_error),
        .rx_ack   (rx_ack),
        .tx_data  (tx_data),
        .tx_wr    (tx_wr),
        .tx_busy  (tx_busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state, written only by the stimulus process.
    bit         chk_en      = 1'b0;
    bit         m_tx_valid  = 1'b0;
    int         m_tx_start  = 0;
    logic [9:0] m_tx_frame  = 10'h3FF;
    bit         m_rx_stable = 1'b0;
    logic [7:0] m_data      = 8'h00;
    logic       m_avail     = 1'b0;
    logic       m_error     = 1'b0;
    int         pin_sel     = 0;
    logic [7:0] pin_exp     = 8'h00;
    bit         abort_seen  = 1'b0;

    // Counters, written only by the compare process.
    int n_total  = 0;
    int n_bad    = 0;
    int busy_run = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        int t;
        if (chk_en) begin
            t = cyc - m_tx_start;
            // Bit k is certainly on the line during [80k, 80k+75] after the strobe.
            if (m_tx_valid && t < c_frame) begin
                if ((t % c_bit) <= 75) check("txd_bit", 8'(uart_txd), 8'(m_tx_frame[t / c_bit]));
                if (t <= 795) check("tx_busy_high", 8'(tx_busy), 8'd1);
            end else begin
                check("txd_idle", 8'(uart_txd), 8'd1);
                check("tx_busy_idle", 8'(tx_busy), 8'd0);
            end

            if (tx_busy) begin
                busy_run++;
            end else if (busy_run > 0) begin
                if (!abort_seen) begin
                    n_total++;
                    if (busy_run < 795 || busy_run > 805) begin
                        n_bad++;
                        $display("FAIL tx_busy_len: got %0d clk, required 795..805", busy_run);
                    end
                end
                busy_run = 0;
            end

            if (m_rx_stable) begin
                check("rx_data", rx_data, m_data);
                check("rx_avail", 8'(rx_avail), 8'(m_avail));
                check("rx_error", 8'(rx_error), 8'(m_error));
            end

            case (pin_sel)
                1: begin
                    check("rst_txd", 8'(uart_txd), 8'd1);
                    check("rst_busy", 8'(tx_busy), 8'd0);
                    check("rst_avail", 8'(rx_avail), 8'd0);
                    check("rst_error", 8'(rx_error), 8'd0);
                    check("rst_data", rx_data, 8'h00);
                end
                2: check("txd_55_bit", 8'(uart_txd), pin_exp);
                3: check("ack_clears_avail", 8'(rx_avail), 8'd0);
                4: begin
                    check("loop_rx_data", rx_data, 8'hA5);
                    check("loop_rx_avail", 8'(rx_avail), 8'd1);
                end
                5: begin
                    check("abort_txd", 8'(uart_txd), 8'd1);
                    check("abort_busy", 8'(tx_busy), 8'd0);
                end
                6: check("stop_low_error", 8'(rx_error), pin_exp);
                default: ;
            endcase
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_tx(input logic [7:0] d);
        tx_data = d;
        tx_wr   = 1'b1;
        step(1);
        tx_wr   = 1'b0;
        if (!(m_tx_valid && (cyc - m_tx_start) < c_frame)) begin
            m_tx_valid = 1'b1;
            m_tx_start = cyc;
            m_tx_frame = {1'b1, d, 1'b0};
        end
    endtask

    task automatic wait_tx_done();
        while (m_tx_valid && (cyc - m_tx_start) < c_frame + 10) step(1);
    endtask

    task automatic wait_rx_avail();
        for (int n = 0; n < 300 && !rx_avail; n++) step(1);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop_bit);
        rxd_drv = 1'b0;
        step(c_bit);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = d[i];
            step(c_bit);
        end
        rxd_drv = stop_bit;
        step(c_bit);
        rxd_drv = 1'b1;
        step(100);
    endtask

    task automatic ack_rx(input int pin);
        rx_ack = 1'b1;
        step(1);
        rx_ack  = 1'b0;
        m_avail = 1'b0;
        m_error = 1'b0;
        pin_sel = pin;
        step(1);
        pin_sel = 0;
    endtask

    initial begin
        step(3);
        reset       = 1'b0;
        chk_en      = 1'b1;
        m_rx_stable = 1'b1;
        pin_sel     = 1;
        step(1);
        pin_sel = 0;
        step(20);

        // 0x55 on the line: 0,1,0,1,... sampled mid-bit.
        send_tx(8'h55);
        for (int k = 0; k < 10; k++) begin
            while ((cyc - m_tx_start) < 40 + c_bit * k) step(1);
            pin_sel = 2;
            pin_exp = 8'(k % 2);
            step(1);
            pin_sel = 0;
        end
        wait_tx_done();
        step(20);

        // Loopback 0xA5, then acknowledge.
        loop_en     = 1'b1;
        m_rx_stable = 1'b0;
        send_tx(8'hA5);
        wait_tx_done();
        wait_rx_avail();
        m_data      = 8'hA5;
        m_avail     = 1'b1;
        m_error     = 1'b0;
        m_rx_stable = 1'b1;
        pin_sel     = 4;
        step(1);
        pin_sel = 0;
        step(10);
        ack_rx(3);
        loop_en = 1'b0;
        step(20);

        // 0x3C with a low stop bit.
        m_rx_stable = 1'b0;
        drive_frame(8'h3C, 1'b0);
`ifdef UART_FRAMING_CHECK_EN
        m_error = 1'b1;
        pin_exp = 8'd1;
`else
        m_data  = 8'h3C;
        m_avail = 1'b1;
        m_error = 1'b0;
        pin_exp = 8'd0;
`endif
        m_rx_stable = 1'b1;
        pin_sel     = 6;
        step(1);
        pin_sel = 0;
        step(10);
        ack_rx(3);
        step(20);

        // Overrun: second byte overwrites the first without a flag.
        m_rx_stable = 1'b0;
        drive_frame(8'h81, 1'b1);
        drive_frame(8'h7E, 1'b1);
        m_data      = 8'h7E;
        m_avail     = 1'b1;
        m_error     = 1'b0;
        m_rx_stable = 1'b1;
        step(10);
        ack_rx(3);
        step(20);

        // 10-clk glitch must not disturb the receiver outputs.
        rxd_drv = 1'b0;
        step(10);
        rxd_drv = 1'b1;
        step(200);

        // Second strobe while busy is ignored.
        loop_en     = 1'b1;
        m_rx_stable = 1'b0;
        send_tx(8'h12);
        step(99);
        send_tx(8'hFF);
        wait_tx_done();
        wait_rx_avail();
        m_data      = 8'h12;
        m_avail     = 1'b1;
        m_error     = 1'b0;
        m_rx_stable = 1'b1;
        step(10);
        ack_rx(3);
        step(20);

        // Reset 300 clk into a frame aborts it.
        m_rx_stable = 1'b0;
        send_tx(8'h34);
        step(299);
        abort_seen = 1'b1;
        reset      = 1'b1;
        step(1);
        reset       = 1'b0;
        m_tx_valid  = 1'b0;
        m_data      = 8'h00;
        m_avail     = 1'b0;
        m_error     = 1'b0;
        m_rx_stable = 1'b1;
        pin_sel     = 5;
        step(1);
        pin_sel = 0;
        step(200);

        chk_en = 1'b0;
        step(1);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/uart.md
UART -- requirements
Module: uart

Interface
REQ-001 The module SHALL have parameter freq_hz, default 100000000, meaning the clk frequency in Hz.
REQ-002 The module SHALL have parameter baud, default 115200, meaning the serial bit rate.
REQ-003 The module SHALL have port clk  input  1  system clock; the block uses one clock, and all logic is on its rising edge.
REQ-004 The module SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 The module SHALL have port uart_rxd  input  1  serial receive line, asynchronous, idle high.
REQ-006 The module SHALL have port uart_txd  output  1  serial transmit line, idle high.
REQ-007 The module SHALL have port rx_data  output  8  last received byte.
REQ-008 The module SHALL have port rx_avail  output  1  received byte pending.
REQ-009 The module SHALL have port rx_error  output  1  framing error flag.
REQ-010 The module SHALL have port rx_ack  input  1  consumer acknowledge of rx_data.
REQ-011 The module SHALL have port tx_data  input  8  byte to send.
REQ-012 The module SHALL have port tx_wr  input  1  one-cycle transmit strobe.
REQ-013 The module SHALL have port tx_busy  output  1  transmitter occupied.

Function
REQ-014 The divisor SHALL be freq_hz/(baud*16), integer-truncated and clamped to a minimum of 1; a tick (enable16) pulses for 1 clk every divisor clks, free-running.
REQ-015 The frame format SHALL be 8N1: start bit 0, data bits LSB first, stop bit 1, each bit lasting 16 ticks.
REQ-016 TX states SHALL be IDLE, START, DATA, STOP.
REQ-017 In TX IDLE, tx_wr=1 on a clk edge SHALL latch tx_data, set tx_busy=1 and drive uart_txd=0 from the next cycle.
REQ-018 After STOP completes (16 ticks of 1), TX SHALL return to IDLE and set tx_busy=0 in the same cycle.
REQ-019 tx_wr while tx_busy=1 SHALL be ignored, and neither the latched byte nor the timing changes.
REQ-020 RX SHALL pass uart_rxd through a 2-flop synchronizer before any use.
REQ-021 RX states SHALL be IDLE, START, DATA, STOP; in IDLE a low synchronized level moves RX to START.
REQ-022 In START, the line SHALL be resampled after 8 ticks (mid-bit); if high (glitch), RX returns to IDLE with no flag change.
REQ-023 Data bits SHALL be sampled every 16 ticks thereafter at mid-bit and shifted in LSB first.
REQ-024 Stop sample = 1 SHALL update rx_data, set rx_avail=1 and clear rx_error.
REQ-025 Stop sample = 0 SHALL set rx_error=1, leave rx_data and rx_avail unchanged, and wait for line high before IDLE.
REQ-026 rx_ack=1 SHALL clear rx_avail and rx_error on the next edge.
REQ-027 If a new valid byte completes in the same cycle as rx_ack, the new byte SHALL win and rx_avail stays 1.
REQ-028 A byte completing while rx_avail=1 SHALL silently overwrite rx_data (overrun, no flag).
REQ-029 TX and RX SHALL be fully independent; loopback uart_txd->uart_rxd is legal.

Reset
REQ-030 reset=1 at a clk edge SHALL force uart_txd=1, tx_busy=0, rx_avail=0, rx_error=0, rx_data=0, both FSMs to IDLE, the divider counter to 0 and the synchronizer to 1s.
REQ-031 Reset mid-frame SHALL abort the frame immediately, with the line high from the next cycle.

Configuration
REQ-032 The macro UART_FRAMING_CHECK_EN SHALL select framing-error handling.
REQ-033 When UART_FRAMING_CHECK_EN is defined, REQ-025 SHALL apply.
REQ-034 When UART_FRAMING_CHECK_EN is undefined, rx_error SHALL be tied 0 and every frame that reaches stop is accepted as valid regardless of the stop sample.

Structure
REQ-035 Package uart_pkg SHALL hold the OVERSAMPLE=16 constant, DATA_BITS=8, and the TX/RX state enum typedefs.
REQ-036 One sub-module, uart_baud_gen (divisor counter producing enable16), SHALL be instantiated once and shared by TX and RX.

Verification (freq_hz=100000000, baud=1152000 -> divisor 5, bit = 80 clk)
REQ-037 Reset then idle SHALL give: uart_txd=1, tx_busy=0, rx_avail=0, rx_error=0, rx_data=0x00.
REQ-038 tx_wr with tx_data=0x55 SHALL make uart_txd show 0,1,0,1,0,1,0,1,0,1 at 80-clk spacing, with tx_busy high for 800 clk (+/-5).
REQ-039 In loopback, sending 0xA5 SHALL give rx_avail=1 and rx_data=0xA5; rx_ack for one cycle SHALL bring rx_avail to 0 the next cycle.
REQ-040 Driving a frame 0x3C with the stop bit low SHALL give rx_error=1, rx_avail=0 and rx_data unchanged (with UART_FRAMING_CHECK_EN); without the macro it SHALL give rx_avail=1, rx_data=0x3C and rx_error=0.
REQ-041 A 10-clk low glitch on uart_rxd SHALL leave no rx_avail and no rx_error.
REQ-042 A second tx_wr (0xFF) sent 100 clk after 0x12 SHALL be ignored, so only 0x12 appears on the line; reset at clk 300 of a frame SHALL give uart_txd=1 and tx_busy=0 next cycle.
